// File: rtl/fpu_dp_adder.sv
`default_nettype none
// ============================================================================
// Module      : fpu_dp_adder
// Description : IEEE-754 binary64 adder. Round-to-nearest-even with gradual
//               underflow. Reports overflow and underflow, and has one
//               registered output stage, so latency is 1 cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_dp_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [63:0] c_qnan    = 64'h7FF8_0000_0000_0000;
  localparam logic [11:0] c_exp_inf = 12'd2047;
  localparam logic [11:0] c_shift_k = 12'd56;

  // Special-operand classification
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  assign w_a_nan = (&a[62:52]) & (|a[51:0]);
  assign w_b_nan = (&b[62:52]) & (|b[51:0]);
  assign w_a_inf = (&a[62:52]) & ~(|a[51:0]);
  assign w_b_inf = (&b[62:52]) & ~(|b[51:0]);

  // Operand ordering and unpacking. X is the operand with the larger magnitude.
  // Comparing the raw exponent/fraction fields orders normals and subnormals
  // correctly.
  logic        w_swap;
  logic [63:0] w_x, w_y;
  logic        w_sx, w_eff_sub;
  logic [11:0] w_ex, w_ey, w_diff;
  logic [52:0] w_mx, w_my;

  assign w_swap    = b[62:0] > a[62:0];
  assign w_x       = w_swap ? b : a;
  assign w_y       = w_swap ? a : b;
  assign w_sx      = w_x[63];
  assign w_eff_sub = w_x[63] ^ w_y[63];
  assign w_ex      = (w_x[62:52] == 11'd0) ? 12'd1 : {1'b0, w_x[62:52]};
  assign w_ey      = (w_y[62:52] == 11'd0) ? 12'd1 : {1'b0, w_y[62:52]};
  assign w_mx      = {|w_x[62:52], w_x[51:0]};
  assign w_my      = {|w_y[62:52], w_y[51:0]};
  assign w_diff    = w_ex - w_ey;

  // Align Y to X. This keeps 53 significand bits plus guard and round bits,
  // and ORs every bit shifted past them into sticky.
  logic [107:0] w_wide;
  logic [54:0]  w_y_al;
  logic         w_y_st;
  always_comb begin
    w_wide = '0;
    w_y_al = '0;
    w_y_st = 1'b0;
    if (w_diff >= c_shift_k) begin
      w_y_st = |w_my;
    end else begin
      w_wide = {w_my, 55'b0} >> w_diff[5:0];
      w_y_al = w_wide[107:53];
      w_y_st = |w_wide[52:0];
    end
  end

  // Significand add/subtract. Layout: [56] carry, [55] hidden, [54:3] fraction,
  // [2] guard, [1] round, [0] sticky.
  logic [55:0] w_x_ext, w_y_ext;
  logic [56:0] w_sum;
  logic        w_zero;
  assign w_x_ext = {w_mx, 3'b000};
  assign w_y_ext = {w_y_al, w_y_st};
  assign w_sum   = w_eff_sub ? ({1'b0, w_x_ext} - {1'b0, w_y_ext})
                             : ({1'b0, w_x_ext} + {1'b0, w_y_ext});
  assign w_zero  = ~(|w_sum);

  // Leading-zero count over the 56-bit normalisation window.
  function automatic logic [5:0] lzc56(input logic [55:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd56;
    found = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(55 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Normalisation. On carry, shift right 1 and keep the lost bit as sticky.
  // Otherwise shift left by the zero count, but stop at exponent 1 so a
  // subnormal result stays subnormal.
  logic [55:0] w_norm;
  logic        w_norm_st;
  logic [11:0] w_nexp, w_lim;
  logic [5:0]  w_lz, w_sh;
  logic        w_subn;
  always_comb begin
    w_norm    = '0;
    w_norm_st = 1'b0;
    w_nexp    = w_ex;
    w_lz      = '0;
    w_lim     = '0;
    w_sh      = '0;
    if (w_sum[56]) begin
      w_norm    = w_sum[56:1];
      w_norm_st = w_sum[0];
      w_nexp    = w_ex + 12'd1;
    end else begin
      w_lz  = lzc56(w_sum[55:0]);
      w_lim = w_ex - 12'd1;
      if ({6'b0, w_lz} <= w_lim) begin
        w_sh = w_lz;
      end else begin
        w_sh = w_lim[5:0];
      end
      w_norm = w_sum[55:0] << w_sh;
      w_nexp = w_ex - {6'b0, w_sh};
    end
    w_subn = ~w_norm[55];
  end

  // Round to nearest, ties to even. A carry out of the significand bumps the
  // exponent. A subnormal that carries into bit 52 becomes the minimum normal.
  logic        w_lsb, w_g, w_r, w_st, w_rup;
  logic [53:0] w_rnd;
  logic [11:0] w_fexp;
  logic [51:0] w_ffrac;
  always_comb begin
    w_lsb   = w_norm[3];
    w_g     = w_norm[2];
    w_r     = w_norm[1];
    w_st    = w_norm[0] | w_norm_st;
    w_rup   = w_g & (w_r | w_st | w_lsb);
    w_rnd   = {1'b0, w_norm[55:3]} + {53'b0, w_rup};
    w_ffrac = w_rnd[51:0];
    if (w_subn) begin
      w_fexp = {11'b0, w_rnd[52]};
    end else begin
      w_fexp = w_nexp + {11'b0, w_rnd[53]};
    end
  end

  // Final selection. Special operands take priority, then exact zero,
  // overflow and the ordinary packed result.
  logic [63:0] w_res;
  logic        w_ov, w_un;
  always_comb begin
    w_res = {w_sx, w_fexp[10:0], w_ffrac};
    w_ov  = 1'b0;
    w_un  = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_res = c_qnan;
    end else if (w_a_inf && w_b_inf) begin
      w_res = (a[63] != b[63]) ? c_qnan : a;
    end else if (w_a_inf) begin
      w_res = a;
    end else if (w_b_inf) begin
      w_res = b;
    end else if (w_zero) begin
      // Cancellation gives +0. Only (-0)+(-0) keeps the sign.
      w_res = {w_sx & ~w_eff_sub, 63'b0};
    end else if (w_fexp >= c_exp_inf) begin
      w_res = {w_sx, 11'h7FF, 52'b0};
      w_ov  = 1'b1;
    end else begin
      w_un  = (w_fexp == 12'd0);
    end
  end

  // Output register stage
  logic [63:0] r_result;
  logic        r_overflow, r_underflow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_result    <= w_res;
      r_overflow  <= w_ov;
      r_underflow <= w_un;
    end
  end

  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fpu_dp_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_dp_adder
// Description : Scoreboard testbench for fpu_dp_adder. Directed vectors go
//               into a queue and a monitor compares the registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_dp_adder;

  typedef struct {
    logic [63:0] res;
    logic        ov;
    logic        un;
    int          id;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] a, b;
  logic [63:0] result;
  logic        overflow, underflow;

  logic        vld;
  logic        vld_q;
  exp_t        sb[$];
  int          total;
  int          bad;
  int          vec_id;

  fpu_dp_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track the one-cycle latency of issued vectors
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld;
  end

  // Monitor: pop and compare whenever a result is due
  always @(negedge clk) begin
    if (vld_q) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underrun: output present with no expected value, result=%h", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || overflow !== e.ov || underflow !== e.un) begin
          bad++;
          $display("FAIL vec%0d: got result=%h ov=%b un=%b, need result=%h ov=%b un=%b",
                   e.id, result, overflow, underflow, e.res, e.ov, e.un);
        end
      end
    end
  end

  task automatic issue(input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] r, input logic ov, input logic un);
    exp_t e;
    @(negedge clk);
    a   = x;
    b   = y;
    vld = 1'b1;
    e.res = r;
    e.ov  = ov;
    e.un  = un;
    e.id  = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [63:0] r,
                           input logic ov, input logic un);
    total++;
    if (result !== r || overflow !== ov || underflow !== un) begin
      bad++;
      $display("FAIL %s: got result=%h ov=%b un=%b, need result=%h ov=%b un=%b",
               name, result, overflow, underflow, r, ov, un);
    end
  endtask

  initial begin
    real ra, rb;
    total  = 0;
    bad    = 0;
    vec_id = 0;
    vld    = 1'b0;
    rst_n  = 1'b0;
    a      = 64'h3FF0_0000_0000_0000;
    b      = 64'h3FF0_0000_0000_0000;

    repeat (3) @(posedge clk);
    #1 check_now("reset_state", 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same sign
    issue($realtobits(4.2), $realtobits(3.2), 64'h401D_9999_9999_999A, 1'b0, 1'b0);
    ra = -6.4; rb = -0.5;
    issue($realtobits(ra), $realtobits(rb), $realtobits(ra + rb), 1'b0, 1'b0);
    // Mixed sign
    ra = 6.4; rb = -0.5;
    issue($realtobits(ra), $realtobits(rb), $realtobits(ra + rb), 1'b0, 1'b0);
    ra = 124054.4312345; rb = -9213743.123655343;
    issue($realtobits(ra), $realtobits(rb), $realtobits(ra + rb), 1'b0, 1'b0);
    ra = 121.3232; rb = -123.1231;
    issue($realtobits(ra), $realtobits(rb), $realtobits(ra + rb), 1'b0, 1'b0);
    // Overflow and underflow
    issue(64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000, 1'b1, 1'b0);
    issue(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 1'b1);
    // Specials and signed zeros
    issue(64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0);
    issue(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1'b0, 1'b0);
    issue(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1'b0, 1'b0);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    issue(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0);
    issue(64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 1'b0, 1'b0);
    // Boundary cases: subnormal into min normal, min normal minus 1 ulp,
    // absorbed operand, and ties-to-even in both directions
    issue(64'h000F_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0010_0000_0000_0000, 1'b0, 1'b0);
    issue(64'h0010_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h000F_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    issue(64'h7FEF_FFFF_FFFF_FFFF, 64'h3FF0_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    issue(64'h3FF0_0000_0000_0000, 64'h3CA0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0);
    issue(64'h3FF0_0000_0000_0000, 64'h3CB8_0000_0000_0000, 64'h3FF0_0000_0000_0002, 1'b0, 1'b0);

    // Reset asserted mid-stream between clock edges
    @(negedge clk);
    vld = 1'b0;
    a   = 64'h3FF0_0000_0000_0000;
    b   = 64'h4000_0000_0000_0000;
    @(posedge clk);
    #1 check_now("pre_reset_sum", 64'h4008_0000_0000_0000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", 64'h0, 1'b0, 1'b0);
    issue($realtobits(4.2), $realtobits(3.2), 64'h401D_9999_9999_999A, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 check_now("reset_hold", 64'h0, 1'b0, 1'b0);

    // Drain and confirm every expected value was consumed
    @(negedge clk);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
